io_periph_ctrl: RTL



---
 rtl/io_periph_pkg.sv | 28 ++
 rtl/io_periph_ctrl_sw_debounce.sv | 92 +++++++++
 rtl/io_periph_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/io_periph_pkg.sv
// io_periph_pkg
//   Shared definitions for the IO peripheral:
//   - word-aligned register offsets inside the peripheral window;
//   - the active-low seven-segment pattern table, bit order gfedcba;
//   - helpers for the hex bank count and the nibble-to-segment decode.
package io_periph_pkg;

   localparam logic [31:0] LEDR_OFF     = 32'h0000_0000;
   localparam logic [31:0] HEX_BASE     = 32'h0000_0010;
   localparam logic [31:0] HEX_MODE_OFF = 32'h0000_0030;
   localparam logic [31:0] SW_OFF       = 32'h0000_0040;

   // Active-low segments: a 0 lights the segment. Bit 6 is g, bit 0 is a.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Four digits are packed into each 32-bit hex bank register.
   function automatic int num_hex_banks(input int n);
      return (n + 3) / 4;
   endfunction

   function automatic logic [6:0] hex_to_7seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/io_periph_ctrl_sw_debounce.sv
// sw_debounce
//   Per-bit switch conditioning: a two-flop synchroniser followed by a
//   counter that accepts a new level only after it has been seen for
//   DEBOUNCE_CYC consecutive cycles. DEBOUNCE_CYC = 0 skips the filter.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   sw_raw        asynchronous switch inputs
//   sw_deb        debounced switch value
//   sw_change     one-cycle pulse after any debounced bit changes
module sw_debounce #(
   parameter int W            = 32,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] sw_raw,
   output logic [W-1:0] sw_deb,
   output logic         sw_change
);

   logic [W-1:0] sync1_r;
   logic [W-1:0] deb_r;
   logic [W-1:0] deb_nxt_s;
   logic         chg_r;

   // First synchroniser stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_r <= {W{1'b0}};
      end else begin
         sync1_r <= sw_raw;
      end
   end

   generate
      if (DEBOUNCE_CYC == 0) begin : g_bypass
         // With no filtering the debounced register is the second sync stage.
         assign deb_nxt_s = sync1_r;
      end else begin : g_filter
         localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
         localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

         logic [W-1:0] sync2_r;

         // Second synchroniser stage.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               sync2_r <= {W{1'b0}};
            end else begin
               sync2_r <= sync1_r;
            end
         end

         for (genvar b = 0; b < W; b++) begin : g_bit
            logic [CNT_W-1:0] cnt_r;

            // Count consecutive disagreeing cycles; any agreement restarts the run.
            always_ff @(posedge i_clk) begin
               if (i_rst) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else if (sync2_r[b] == deb_r[b]) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else if (cnt_r == CNT_MAX) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

            // The disagreeing cycle that finds the count at its maximum is
            // the DEBOUNCE_CYC-th one, so the new level is taken then.
            assign deb_nxt_s[b] = ((sync2_r[b] != deb_r[b]) && (cnt_r == CNT_MAX))
                                  ? sync2_r[b] : deb_r[b];
         end
      end
   endgenerate

   // Debounced value and change strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         deb_r <= {W{1'b0}};
         chg_r <= 1'b0;
      end else begin
         deb_r <= deb_nxt_s;
         chg_r <= |(deb_nxt_s ^ deb_r);
      end
   end

   assign sw_deb    = deb_r;
   assign sw_change = chg_r;

endmodule

// File: rtl/io_periph_ctrl.sv
// io_periph_ctrl
//   Memory-mapped LED / seven-segment / switch peripheral for the LSU.
//   Registers (word offsets): LEDR 0x00, HEX banks 0x10.., HEX_MODE 0x30,
//   SW 0x40 (read-only). Reads return data one cycle after i_rden.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_addr            byte address, bits [1:0] ignored
//   i_wdata, i_bmask  write data and byte enables, used when i_wren=1
//   i_rden            read strobe; o_rdata/o_rvalid answer next cycle
//   i_io_sw           raw switches
//   o_io_ledr         LED register
//   o_io_hex          active-low segments, digit k at [7k+6:7k]
//   o_sw_change       pulse after the debounced switch value changes
module io_periph_ctrl #(
   parameter int LEDR_W       = 32,
   parameter int SW_W         = 32,
   parameter int NUM_HEX      = 8,
   parameter int DEBOUNCE_CYC = 16,
   parameter int ADDR_W       = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [31:0]          i_wdata,
   input  logic [3:0]           i_bmask,
   input  logic                 i_wren,
   input  logic                 i_rden,
   output logic [31:0]          o_rdata,
   output logic                 o_rvalid,
   input  logic [SW_W-1:0]      i_io_sw,
   output logic [LEDR_W-1:0]    o_io_ledr,
   output logic [7*NUM_HEX-1:0] o_io_hex,
   output logic                 o_sw_change
);
   import io_periph_pkg::*;

   localparam int NUM_BANKS = num_hex_banks(NUM_HEX);

   logic [31:0]          addr_s;
   logic [31:0]          hex_bank_s;
   logic                 hex_hit_s;
   logic                 wr_ledr_s;
   logic                 wr_mode_s;
   logic                 wr_hex_s;

   logic [LEDR_W-1:0]    ledr_r;
   logic [LEDR_W-1:0]    ledr_nxt_s;
   logic [6:0]           hex_r     [NUM_HEX];
   logic [6:0]           hex_nxt_s [NUM_HEX];
   logic [NUM_HEX-1:0]   mode_r;
   logic [NUM_HEX-1:0]   mode_nxt_s;
   logic [7*NUM_HEX-1:0] seg_r;
   logic [7*NUM_HEX-1:0] seg_nxt_s;
   logic [31:0]          rdata_s;
   logic [31:0]          rdata_r;
   logic                 rvalid_r;
   logic [SW_W-1:0]      sw_deb_s;
   logic                 sw_change_s;

   // Word-aligned address; hex bank index is only meaningful on a hex hit.
   assign addr_s     = 32'(i_addr) & 32'hFFFF_FFFC;
   assign hex_hit_s  = (addr_s >= HEX_BASE) && (addr_s < (HEX_BASE + 32'(4 * NUM_BANKS)));
   assign hex_bank_s = (addr_s - HEX_BASE) >> 2'd2;
   assign wr_ledr_s  = i_wren && (addr_s == LEDR_OFF);
   assign wr_mode_s  = i_wren && (addr_s == HEX_MODE_OFF);
   assign wr_hex_s   = i_wren && hex_hit_s;

   // Byte-masked next state; segments are decoded from the next state so the
   // registered segment outputs change on the same edge as the registers.
   always_comb begin
      ledr_nxt_s = ledr_r;
      mode_nxt_s = mode_r;
      seg_nxt_s  = {(7*NUM_HEX){1'b0}};
      for (int i = 0; i < LEDR_W; i++) begin
         ledr_nxt_s[i] = (wr_ledr_s && i_bmask[i/8]) ? i_wdata[i] : ledr_r[i];
      end
      for (int k = 0; k < NUM_HEX; k++) begin
         mode_nxt_s[k] = (wr_mode_s && i_bmask[k/8]) ? i_wdata[k] : mode_r[k];
         hex_nxt_s[k]  = (wr_hex_s && (hex_bank_s == 32'(k/4)) && i_bmask[k%4])
                         ? i_wdata[8*(k%4) +: 7] : hex_r[k];
         seg_nxt_s[7*k +: 7] = mode_nxt_s[k] ? hex_to_7seg(hex_nxt_s[k][3:0]) : hex_nxt_s[k];
      end
   end

   // Read mux over the current (pre-write) register contents.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (addr_s == LEDR_OFF) begin
         rdata_s = 32'(ledr_r);
      end else if (addr_s == HEX_MODE_OFF) begin
         rdata_s = 32'(mode_r);
      end else if (addr_s == SW_OFF) begin
         rdata_s = 32'(sw_deb_s);
      end else if (hex_hit_s) begin
         for (int k = 0; k < NUM_HEX; k++) begin
            rdata_s[8*(k%4) +: 7] = rdata_s[8*(k%4) +: 7] |
                                    ((hex_bank_s == 32'(k/4)) ? hex_r[k] : 7'h00);
         end
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   // Register file and read handshake.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ledr_r   <= {LEDR_W{1'b0}};
         mode_r   <= {NUM_HEX{1'b0}};
         seg_r    <= {NUM_HEX{7'h7F}};
         rdata_r  <= 32'h0000_0000;
         rvalid_r <= 1'b0;
         for (int k = 0; k < NUM_HEX; k++) begin
            hex_r[k] <= 7'h7F;
         end
      end else begin
         ledr_r   <= ledr_nxt_s;
         mode_r   <= mode_nxt_s;
         seg_r    <= seg_nxt_s;
         rvalid_r <= i_rden;
         for (int k = 0; k < NUM_HEX; k++) begin
            hex_r[k] <= hex_nxt_s[k];
         end
         if (i_rden) begin
            rdata_r <= rdata_s;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   sw_debounce #(
      .W            (SW_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_sw_debounce (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .sw_raw    (i_io_sw),
      .sw_deb    (sw_deb_s),
      .sw_change (sw_change_s)
   );

   assign o_io_ledr   = ledr_r;
   assign o_io_hex    = seg_r;
   assign o_rdata     = rdata_r;
   assign o_rvalid    = rvalid_r;
   assign o_sw_change = sw_change_s;

endmodule
